fetch_unit: RTL

Instruction fetch stage that drives the instruction ROM's address port and consumes its registered 16-bit data output. It holds the program counter and compensates for the ROM's one-cycle read latency. A predecoder and a 2-bit branch history table (BHT) predict BRA/LOP direction with zero-bubble redirection. Fetched instructions go to decode through a valid/ready handshake. Execute drives mispredict redirects and BHT training.

---
 rtl/fetch_unit.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit
// ----------
// Instruction fetch stage in front of a synchronous instruction ROM with a
// one-cycle registered read. The ROM address is computed combinationally
// from the word currently on ROM_DATA, so that word's own predecoded branch
// target can be fetched on the very next edge (zero-bubble taken branches).
//
// Optional feature: define BPRED_EN to build the 2-bit branch history table
// and the predicted-taken path. Without it, fetch is strictly sequential
// apart from reset, redirects and stall replay, and UPD_* are ignored.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   ROM_ADDR            next fetch address (combinational), sampled by the ROM
//   ROM_DATA            ROM word for the address sampled on the previous edge
//   OUT_VALID/READY     handshake towards decode
//   OUT_INSTR/PC        fetched instruction and its address
//   OUT_PRED_TAKEN      fetch predicted this instruction taken
//   REDIRECT_VALID/PC   flush from execute, highest priority after reset
//   UPD_VALID/PC/TAKEN  branch history training from execute
module fetch_unit #(
    parameter int         BHT_ENTRIES = 16,
    parameter logic [9:0] RESET_PC    = 10'd0
) (
    input  logic        CLK,
    input  logic        RST,
    output logic [9:0]  ROM_ADDR,
    input  logic [15:0] ROM_DATA,
    output logic        OUT_VALID,
    input  logic        OUT_READY,
    output logic [15:0] OUT_INSTR,
    output logic [9:0]  OUT_PC,
    output logic        OUT_PRED_TAKEN,
    input  logic        REDIRECT_VALID,
    input  logic [9:0]  REDIRECT_PC,
    input  logic        UPD_VALID,
    input  logic [9:0]  UPD_PC,
    input  logic        UPD_TAKEN
);

    // Address whose data is on ROM_DATA in the current cycle.
    logic [9:0]  f_pc_reg;
    logic [9:0]  f_pc_next;

    logic        out_valid_reg;
    logic [15:0] out_instr_reg;
    logic [9:0]  out_pc_reg;
    logic        out_pred_reg;

    logic        stall;
    logic [9:0]  pc_seq;
    logic        pred_taken;

    assign stall  = out_valid_reg && !OUT_READY;
    assign pc_seq = f_pc_reg + 10'd1;

`ifdef BPRED_EN
    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic              is_branch;
    logic [9:0]        target;
    logic [IDX_W-1:0]  lookup_idx;
    logic [1:0]        lookup_ctr;
    // All counters flattened so the lookup is a simple indexed part-select.
    logic [2*BHT_ENTRIES-1:0] bht_flat;
    logic              unused_upd;

    assign is_branch  = (ROM_DATA[15:12] == 4'hC) || (ROM_DATA[15:12] == 4'hF);
    assign target     = f_pc_reg + {{2{ROM_DATA[7]}}, ROM_DATA[7:0]};
    assign lookup_idx = f_pc_reg[IDX_W-1:0];
    assign lookup_ctr = bht_flat[{lookup_idx, 1'b0} +: 2];
    // Counter values 10 and 11 predict taken, i.e. the MSB.
    assign pred_taken = is_branch && lookup_ctr[1];
    assign unused_upd = ^UPD_PC;

    genvar gi;
    generate
        for (gi = 0; gi < BHT_ENTRIES; gi++) begin : bht_gen
            logic [1:0] ctr_reg;
            logic       hit;

            assign hit = UPD_VALID && (UPD_PC[IDX_W-1:0] == IDX_W'(gi));

            // Lookup reads ctr_reg before this edge, so a same-cycle update
            // to the looked-up entry is only seen by later predictions.
            always_ff @(posedge CLK) begin
                if (RST) begin
                    ctr_reg <= 2'b01;
                end else if (hit) begin
                    if (UPD_TAKEN && ctr_reg != 2'b11)
                        ctr_reg <= ctr_reg + 2'b01;
                    else if (!UPD_TAKEN && ctr_reg != 2'b00)
                        ctr_reg <= ctr_reg - 2'b01;
                end
            end

            assign bht_flat[2*gi +: 2] = ctr_reg;
        end
    endgenerate
`else
    logic unused_upd;

    assign pred_taken = 1'b0;
    assign unused_upd = ^{UPD_VALID, UPD_PC, UPD_TAKEN};
`endif

    // Next fetch address. Stall replays f_pc so ROM_DATA keeps presenting
    // the word that is waiting to enter the output register.
    always_comb begin
        f_pc_next = pc_seq;
        if (RST)
            f_pc_next = RESET_PC;
        else if (REDIRECT_VALID)
            f_pc_next = REDIRECT_PC;
        else if (stall)
            f_pc_next = f_pc_reg;
`ifdef BPRED_EN
        else if (pred_taken)
            f_pc_next = target;
`endif
    end

    assign ROM_ADDR = f_pc_next;

    always_ff @(posedge CLK) begin
        if (RST)
            f_pc_reg <= RESET_PC;
        else
            f_pc_reg <= f_pc_next;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            out_valid_reg <= 1'b0;
            out_instr_reg <= 16'h0000;
            out_pc_reg    <= 10'd0;
            out_pred_reg  <= 1'b0;
        end else if (REDIRECT_VALID) begin
            // The word on ROM_DATA is from the wrong path; squash it.
            out_valid_reg <= 1'b0;
        end else if (!stall) begin
            out_valid_reg <= 1'b1;
            out_instr_reg <= ROM_DATA;
            out_pc_reg    <= f_pc_reg;
            out_pred_reg  <= pred_taken;
        end
    end

    assign OUT_VALID      = out_valid_reg;
    assign OUT_INSTR      = out_instr_reg;
    assign OUT_PC         = out_pc_reg;
    assign OUT_PRED_TAKEN = out_pred_reg;

endmodule
